mem_rd_arb: RTL and testbench

MEM_RD_ARB -- requirements
Module: mem_rd_arb

---
 rtl/mem_rd_arb_pkg.sv | 21 ++
 rtl/mem_rd_arb_grant.sv | 45 ++++
 rtl/mem_rd_arb.sv | 152 +++++++++++++++
 tb/tb_mem_rd_arb.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_arb_pkg.sv
// Shared constants and types for the two-requester AXI4 read arbiter.
// Response checking is compiled in only when MEM_RD_ARB_RESP_CHK_EN is defined.
package mem_rd_arb_pkg;

    localparam logic [2:0] ARSIZE_4B    = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADDR = 1'b1
    } state_t;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_idx_t;

endpackage

// File: rtl/mem_rd_arb_grant.sv
// Fixed-priority grant (requester 0 first) with a starvation counter that
// hands one grant to requester 1 after STARVE_LIMIT consecutive losses.
module mem_rd_arb_grant #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic grant_en,
    input  logic req0_valid,
    input  logic req1_valid,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (grant_en) begin
            if (req0_valid && req1_valid) begin
                if (starve_cnt == LIMIT) gnt1 = 1'b1;
                else                     gnt0 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Counts only the grants that requester 1 actually lost.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt <= 8'd0;
        end else if (gnt1) begin
            starve_cnt <= 8'd0;
        end else if (gnt0 && req1_valid && starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mem_rd_arb.sv
// Two-requester AXI4 read arbiter: one AR in flight per grant, R beats routed
// by rid[0]. Define MEM_RD_ARB_RESP_CHK_EN to enable error-response tracking.
module mem_rd_arb
    import mem_rd_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        mem_clk,
    input  logic        mem_resetn,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic [7:0]  req0_len,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [31:0] req0_rdata,
    output logic        req0_rlast,
    input  logic        req0_rready,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [7:0]  req1_len,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [31:0] req1_rdata,
    output logic        req1_rlast,
    input  logic        req1_rready,
    output logic [7:0]  mem_arid,
    output logic [31:0] mem_araddr,
    output logic [7:0]  mem_arlen,
    output logic [2:0]  mem_arsize,
    output logic [1:0]  mem_arburst,
    output logic        mem_arlock,
    output logic        mem_arvalid,
    input  logic        mem_arready,
    input  logic [7:0]  mem_rid,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  mem_rresp,
    input  logic        mem_rlast,
    input  logic        mem_rvalid,
    output logic        mem_rready,
    output logic [1:0]  err_resp,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t      state, state_nxt;
    logic [3:0]  outstanding;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    req_idx_t    ar_idx;
    logic        grant_en, gnt0, gnt1, gnt_any;
    logic        ar_hs, r_hs, r_last_hs, stray, route1;

    // Handshakes: a transfer happens on the edge where valid and ready are both 1;
    // once raised, mem_arvalid and its fields hold until that edge.
    assign grant_en = mem_resetn && (state == ST_IDLE) && (outstanding < MAX_OUT);
    assign gnt_any  = gnt0 | gnt1;

    mem_rd_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk        (mem_clk),
        .resetn     (mem_resetn),
        .grant_en   (grant_en),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;

    assign mem_arvalid = (state == ST_ADDR);
    assign mem_araddr  = ar_addr;
    assign mem_arlen   = ar_len;
    assign mem_arid    = {7'b0, ar_idx};
    assign mem_arsize  = ARSIZE_4B;
    assign mem_arburst = ARBURST_INCR;
    assign mem_arlock  = 1'b0;
    assign ar_hs       = mem_arvalid & mem_arready;

    assign stray       = |mem_rid[7:1];
    assign route1      = mem_rid[0];
    assign req0_rvalid = mem_rvalid & ~stray & ~route1;
    assign req1_rvalid = mem_rvalid & ~stray & route1;
    assign req0_rdata  = mem_rdata;
    assign req1_rdata  = mem_rdata;
    assign req0_rlast  = mem_rlast;
    assign req1_rlast  = mem_rlast;
    // Stray IDs are always sunk so they cannot block the channel.
    assign mem_rready  = mem_resetn & (stray | (route1 ? req1_rready : req0_rready));
    assign r_hs        = mem_rvalid & mem_rready;
    assign r_last_hs   = r_hs & mem_rlast;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (gnt_any) state_nxt = ST_ADDR;
            ST_ADDR: if (ar_hs)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!mem_resetn) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge mem_clk) begin
        if (!mem_resetn) begin
            ar_addr <= 32'd0;
            ar_len  <= 8'd0;
            ar_idx  <= REQ_0;
        end else if (gnt_any) begin
            ar_addr <= gnt1 ? req1_addr : req0_addr;
            ar_len  <= gnt1 ? req1_len  : req0_len;
            ar_idx  <= req_idx_t'(gnt1);
        end
    end

    // A last beat with nothing outstanding (e.g. left over from before reset) is ignored.
    always_ff @(posedge mem_clk) begin
        if (!mem_resetn) begin
            outstanding <= 4'd0;
        end else if (ar_hs && !r_last_hs) begin
            outstanding <= outstanding + 4'd1;
        end else if (r_last_hs && !ar_hs && outstanding != 4'd0) begin
            outstanding <= outstanding - 4'd1;
        end
    end

`ifdef MEM_RD_ARB_RESP_CHK_EN
    logic resp_err;
    assign resp_err = (mem_rresp == RESP_SLVERR) || (mem_rresp == RESP_DECERR);

    always_ff @(posedge mem_clk) begin
        if (!mem_resetn) begin
            err_resp <= 2'b00;
            err_cnt  <= 8'd0;
        end else if (r_hs && resp_err) begin
            err_resp[route1] <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^mem_rresp;
    assign err_resp     = 2'b00;
    assign err_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_mem_rd_arb.sv
// Directed bench for mem_rd_arb with default parameters (MAX_OUTSTANDING 4,
// STARVE_LIMIT 8); error expectations follow MEM_RD_ARB_RESP_CHK_EN.
module tb_mem_rd_arb;

    logic        mem_clk = 1'b0;
    logic        mem_resetn;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic [7:0]  req0_len, req1_len;
    logic        req0_ready, req1_ready;
    logic        req0_rvalid, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_rlast, req1_rlast;
    logic        req0_rready, req1_rready;
    logic [7:0]  mem_arid;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    logic        mem_arlock, mem_arvalid, mem_arready;
    logic [7:0]  mem_rid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rlast, mem_rvalid, mem_rready;
    logic [1:0]  err_resp;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

`ifdef MEM_RD_ARB_RESP_CHK_EN
    localparam logic [1:0] EXP_ERR_RESP = 2'b10;
    localparam logic [7:0] EXP_ERR_CNT  = 8'd1;
`else
    localparam logic [1:0] EXP_ERR_RESP = 2'b00;
    localparam logic [7:0] EXP_ERR_CNT  = 8'd0;
`endif

    always #5 mem_clk = ~mem_clk;

    mem_rd_arb dut (
        .mem_clk(mem_clk), .mem_resetn(mem_resetn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_rlast(req0_rlast), .req0_rready(req0_rready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_rlast(req1_rlast), .req1_rready(req1_rready),
        .mem_arid(mem_arid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
        .mem_arburst(mem_arburst), .mem_arlock(mem_arlock), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rid(mem_rid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .err_resp(err_resp), .err_cnt(err_cnt)
    );

    task automatic step();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_addr = 0; req0_len = 0; req0_rready = 0;
        req1_valid = 0; req1_addr = 0; req1_len = 0; req1_rready = 0;
        mem_arready = 0; mem_rid = 0; mem_rdata = 0; mem_rresp = 0;
        mem_rlast = 0; mem_rvalid = 0;
    endtask

    task automatic do_reset();
        mem_resetn = 0;
        clear_inputs();
        step();
        step();
        mem_resetn = 1;
    endtask

    task automatic grant_req(input logic idx, input logic [31:0] addr, input logic [7:0] len);
        bit done = 0;
        if (idx) begin req1_valid = 1; req1_addr = addr; req1_len = len; end
        else     begin req0_valid = 1; req0_addr = addr; req0_len = len; end
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (idx ? req1_ready : req0_ready) done = 1;
            step();
        end
        if (idx) req1_valid = 0; else req0_valid = 0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL grant_timeout idx %0d got no ready within 20 cycles", idx); end
    endtask

    task automatic finish_ar(input bit with_rlast);
        mem_arready = 1;
        if (with_rlast) begin mem_rvalid = 1; mem_rid = 8'h00; mem_rlast = 1; req0_rready = 1; end
        step();
        mem_arready = 0; mem_rvalid = 0; mem_rlast = 0; req0_rready = 0;
    endtask

    task automatic send_beat(input logic [7:0] rid, input logic [1:0] resp, input logic last);
        mem_rvalid = 1; mem_rid = rid; mem_rresp = resp; mem_rlast = last;
        req0_rready = 1; req1_rready = 1;
        step();
        mem_rvalid = 0; mem_rresp = 0; mem_rlast = 0; req0_rready = 0; req1_rready = 0;
    endtask

    task automatic test_reset();
        mem_resetn = 0;
        clear_inputs();
        req0_valid = 1; req1_valid = 1; mem_rvalid = 1; req0_rready = 1; req1_rready = 1;
        step();
        step();
        checks++; if (req0_ready !== 1'b0)   begin errors++; $display("FAIL reset_req0_ready got %0h exp 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0)   begin errors++; $display("FAIL reset_req1_ready got %0h exp 0", req1_ready); end
        checks++; if (mem_arvalid !== 1'b0)  begin errors++; $display("FAIL reset_arvalid got %0h exp 0", mem_arvalid); end
        checks++; if (mem_rready !== 1'b0)   begin errors++; $display("FAIL reset_rready got %0h exp 0", mem_rready); end
        checks++; if (mem_araddr !== 32'h0)  begin errors++; $display("FAIL reset_araddr got %h exp 0", mem_araddr); end
        checks++; if (mem_arlen !== 8'h0)    begin errors++; $display("FAIL reset_arlen got %h exp 0", mem_arlen); end
        checks++; if (mem_arid !== 8'h0)     begin errors++; $display("FAIL reset_arid got %h exp 0", mem_arid); end
        checks++; if (err_resp !== 2'b00)    begin errors++; $display("FAIL reset_err_resp got %b exp 00", err_resp); end
        checks++; if (err_cnt !== 8'd0)      begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (dut.outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", dut.outstanding); end
        mem_resetn = 1;
        clear_inputs();
        step();
    endtask

    task automatic test_single_burst();
        do_reset();
        req0_valid = 1; req0_addr = 32'h0000_1000; req0_len = 8'd15;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0h exp 1", req0_ready); end
        step();
        req0_valid = 0;
        req1_valid = 1;
        for (int c = 0; c < 4; c++) begin
            mem_arready = (c == 3);
            #1;
            checks++; if (mem_arvalid !== 1'b1)        begin errors++; $display("FAIL single_arvalid c%0d got %0h exp 1", c, mem_arvalid); end
            checks++; if (mem_araddr !== 32'h0000_1000) begin errors++; $display("FAIL single_araddr c%0d got %h exp 00001000", c, mem_araddr); end
            checks++; if (mem_arlen !== 8'd15)         begin errors++; $display("FAIL single_arlen c%0d got %0d exp 15", c, mem_arlen); end
            checks++; if (mem_arid !== 8'h00)          begin errors++; $display("FAIL single_arid c%0d got %h exp 00", c, mem_arid); end
            checks++; if (mem_arsize !== 3'b010)       begin errors++; $display("FAIL single_arsize c%0d got %b exp 010", c, mem_arsize); end
            checks++; if (mem_arburst !== 2'b01)       begin errors++; $display("FAIL single_arburst c%0d got %b exp 01", c, mem_arburst); end
            checks++; if (mem_arlock !== 1'b0)         begin errors++; $display("FAIL single_arlock c%0d got %0h exp 0", c, mem_arlock); end
            checks++; if (req1_ready !== 1'b0)         begin errors++; $display("FAIL single_no_grant_in_addr c%0d got %0h exp 0", c, req1_ready); end
            step();
        end
        req1_valid = 0; mem_arready = 0;
        #1;
        checks++; if (mem_arvalid !== 1'b0)      begin errors++; $display("FAIL single_arvalid_drop got %0h exp 0", mem_arvalid); end
        checks++; if (dut.outstanding !== 4'd1)  begin errors++; $display("FAIL single_outstanding got %0d exp 1", dut.outstanding); end
        req0_rready = 1;
        for (int i = 0; i < 16; i++) begin
            mem_rvalid = 1; mem_rid = 8'h00; mem_rdata = 32'hA000_0000 + i; mem_rlast = (i == 15);
            #1;
            checks++; if (req0_rvalid !== 1'b1)                 begin errors++; $display("FAIL beat_rvalid0 b%0d got %0h exp 1", i, req0_rvalid); end
            checks++; if (req1_rvalid !== 1'b0)                 begin errors++; $display("FAIL beat_rvalid1 b%0d got %0h exp 0", i, req1_rvalid); end
            checks++; if (req0_rdata !== 32'hA000_0000 + i)     begin errors++; $display("FAIL beat_rdata b%0d got %h exp %h", i, req0_rdata, 32'hA000_0000 + i); end
            checks++; if (req0_rlast !== (i == 15))             begin errors++; $display("FAIL beat_rlast b%0d got %0h exp %0h", i, req0_rlast, (i == 15)); end
            checks++; if (mem_rready !== 1'b1)                  begin errors++; $display("FAIL beat_rready b%0d got %0h exp 1", i, mem_rready); end
            step();
        end
        clear_inputs();
        #1;
        checks++; if (dut.outstanding !== 4'd0) begin errors++; $display("FAIL single_drain got %0d exp 0", dut.outstanding); end
    endtask

    task automatic test_starvation();
        int seq[$];
        int k = 0;
        do_reset();
        req0_valid = 1; req0_addr = 32'h0000_0100; req0_len = 8'd0;
        req1_valid = 1; req1_addr = 32'h0000_0200; req1_len = 8'd0;
        mem_arready = 1;
        // A stray-ID last beat every cycle keeps the outstanding count pinned at 0.
        mem_rvalid = 1; mem_rid = 8'h04; mem_rlast = 1;
        for (int c = 0; c < 100 && seq.size() < 18; c++) begin
            #1;
            if (req0_ready && req1_ready) begin
                checks++; errors++; $display("FAIL starve_both_ready cycle %0d got 11 exp one-hot", c);
            end else if (req1_ready) begin
                seq.push_back(1);
                checks++; if (dut.u_grant.starve_cnt !== 8'd8) begin errors++; $display("FAIL starve_at_req1 got %0d exp 8", dut.u_grant.starve_cnt); end
                k = 0;
            end else if (req0_ready) begin
                seq.push_back(0);
                checks++; if (dut.u_grant.starve_cnt !== 8'(k)) begin errors++; $display("FAIL starve_cnt got %0d exp %0d", dut.u_grant.starve_cnt, k); end
                k++;
            end
            step();
        end
        checks++; if (seq.size() != 18) begin errors++; $display("FAIL starve_grant_count got %0d exp 18", seq.size()); end
        for (int i = 0; i < seq.size(); i++) begin
            checks++; if (seq[i] != ((i == 8 || i == 17) ? 1 : 0)) begin errors++; $display("FAIL starve_seq g%0d got %0d exp %0d", i, seq[i], (i == 8 || i == 17)); end
        end
        req0_valid = 0; req1_valid = 0;
        step();
        step();
        clear_inputs();
        #1;
        checks++; if (dut.outstanding !== 4'd0) begin errors++; $display("FAIL starve_outstanding got %0d exp 0", dut.outstanding); end
    endtask

    task automatic test_outstanding_limit();
        int n = 0;
        do_reset();
        mem_arready = 1;
        req0_valid = 1; req0_addr = 32'h0000_2000; req0_len = 8'd3;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (mem_arvalid && mem_arready) n++;
            step();
        end
        #1;
        checks++; if (n != 4)                   begin errors++; $display("FAIL limit_ar_count got %0d exp 4", n); end
        checks++; if (req0_ready !== 1'b0)      begin errors++; $display("FAIL limit_ready_held got %0h exp 0", req0_ready); end
        checks++; if (dut.outstanding !== 4'd4) begin errors++; $display("FAIL limit_outstanding got %0d exp 4", dut.outstanding); end
        mem_rvalid = 1; mem_rid = 8'h00; mem_rlast = 1; req0_rready = 1;
        step();
        mem_rvalid = 0; mem_rlast = 0; req0_rready = 0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (mem_arvalid && mem_arready) n++;
            step();
        end
        #1;
        checks++; if (n != 1)                   begin errors++; $display("FAIL limit_fifth_ar got %0d exp 1", n); end
        checks++; if (dut.outstanding !== 4'd4) begin errors++; $display("FAIL limit_refill got %0d exp 4", dut.outstanding); end
        clear_inputs();
    endtask

    task automatic test_count_edges();
        do_reset();
        grant_req(0, 32'h0000_3000, 8'd0); finish_ar(0);
        grant_req(0, 32'h0000_3004, 8'd0); finish_ar(0);
        #1;
        checks++; if (dut.outstanding !== 4'd2) begin errors++; $display("FAIL count_two got %0d exp 2", dut.outstanding); end
        grant_req(0, 32'h0000_3008, 8'd0); finish_ar(1);
        #1;
        checks++; if (dut.outstanding !== 4'd2) begin errors++; $display("FAIL count_same_cycle got %0d exp 2", dut.outstanding); end
        send_beat(8'h00, 2'b00, 1);
        send_beat(8'h00, 2'b00, 1);
        #1;
        checks++; if (dut.outstanding !== 4'd0) begin errors++; $display("FAIL count_drain got %0d exp 0", dut.outstanding); end
        send_beat(8'h00, 2'b00, 1);
        #1;
        checks++; if (dut.outstanding !== 4'd0) begin errors++; $display("FAIL count_underflow got %0d exp 0", dut.outstanding); end
    endtask

    task automatic test_routing();
        do_reset();
        mem_rvalid = 1; mem_rid = 8'h01; mem_rdata = 32'hDEAD_BEEF; mem_rlast = 0;
        req0_rready = 1; req1_rready = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (mem_rready !== 1'b0)          begin errors++; $display("FAIL route_hold_rready c%0d got %0h exp 0", c, mem_rready); end
            checks++; if (req1_rvalid !== 1'b1)         begin errors++; $display("FAIL route_rvalid1 c%0d got %0h exp 1", c, req1_rvalid); end
            checks++; if (req0_rvalid !== 1'b0)         begin errors++; $display("FAIL route_rvalid0 c%0d got %0h exp 0", c, req0_rvalid); end
            checks++; if (req1_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL route_rdata1 c%0d got %h exp deadbeef", c, req1_rdata); end
            step();
        end
        req1_rready = 1;
        #1;
        checks++; if (mem_rready !== 1'b1) begin errors++; $display("FAIL route_release got %0h exp 1", mem_rready); end
        step();
        mem_rid = 8'h00; req0_rready = 0;
        #1;
        checks++; if (mem_rready !== 1'b0) begin errors++; $display("FAIL route_req0_stall got %0h exp 0", mem_rready); end
        step();
        mem_rid = 8'h04; req1_rready = 0;
        #1;
        checks++; if (mem_rready !== 1'b1)  begin errors++; $display("FAIL stray_rready got %0h exp 1", mem_rready); end
        checks++; if (req0_rvalid !== 1'b0) begin errors++; $display("FAIL stray_rvalid0 got %0h exp 0", req0_rvalid); end
        checks++; if (req1_rvalid !== 1'b0) begin errors++; $display("FAIL stray_rvalid1 got %0h exp 0", req1_rvalid); end
        step();
        clear_inputs();
    endtask

    task automatic test_req1_crossing();
        do_reset();
        grant_req(1, 32'h0000_0FFC, 8'd3);
        #1;
        checks++; if (mem_arid !== 8'h01)          begin errors++; $display("FAIL cross_arid got %h exp 01", mem_arid); end
        checks++; if (mem_araddr !== 32'h0000_0FFC) begin errors++; $display("FAIL cross_araddr got %h exp 00000ffc", mem_araddr); end
        checks++; if (mem_arlen !== 8'd3)          begin errors++; $display("FAIL cross_arlen got %0d exp 3", mem_arlen); end
        finish_ar(0);
    endtask

    task automatic test_err_and_reset();
        do_reset();
        send_beat(8'h01, 2'b10, 0);
        send_beat(8'h00, 2'b00, 0);
        #1;
        checks++; if (err_resp !== EXP_ERR_RESP) begin errors++; $display("FAIL err_resp got %b exp %b", err_resp, EXP_ERR_RESP); end
        checks++; if (err_cnt !== EXP_ERR_CNT)   begin errors++; $display("FAIL err_cnt got %0d exp %0d", err_cnt, EXP_ERR_CNT); end
        req1_valid = 1; req1_addr = 32'h0000_5000;
        grant_req(0, 32'h0000_4000, 8'd1); finish_ar(0);
        grant_req(0, 32'h0000_4010, 8'd1);
        #1;
        checks++; if (mem_arvalid !== 1'b1)              begin errors++; $display("FAIL pre_reset_arvalid got %0h exp 1", mem_arvalid); end
        checks++; if (dut.u_grant.starve_cnt !== 8'd2)   begin errors++; $display("FAIL pre_reset_starve got %0d exp 2", dut.u_grant.starve_cnt); end
        req1_valid = 0;
        mem_resetn = 0;
        step();
        checks++; if (mem_arvalid !== 1'b0)              begin errors++; $display("FAIL mid_reset_arvalid got %0h exp 0", mem_arvalid); end
        checks++; if (dut.outstanding !== 4'd0)          begin errors++; $display("FAIL mid_reset_outstanding got %0d exp 0", dut.outstanding); end
        checks++; if (dut.u_grant.starve_cnt !== 8'd0)   begin errors++; $display("FAIL mid_reset_starve got %0d exp 0", dut.u_grant.starve_cnt); end
        checks++; if (err_resp !== 2'b00)                begin errors++; $display("FAIL mid_reset_err_resp got %b exp 00", err_resp); end
        checks++; if (err_cnt !== 8'd0)                  begin errors++; $display("FAIL mid_reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (mem_araddr !== 32'h0)              begin errors++; $display("FAIL mid_reset_araddr got %h exp 0", mem_araddr); end
        mem_resetn = 1;
        clear_inputs();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        mem_resetn = 0;
        clear_inputs();
        test_reset();
        test_single_burst();
        test_starvation();
        test_outstanding_limit();
        test_count_edges();
        test_routing();
        test_req1_crossing();
        test_err_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
